// File: rtl/rng_pkg.sv
// rng_pkg: shared types for the random-bit packer.
//   whiten_state_t : von Neumann corrector state (waiting for first or second bit of a pair).
//   vn_keep        : returns 1 when a bit pair carries an unbiased bit (bits differ).
package rng_pkg;

  typedef enum logic [0:0] {
    WAIT_FIRST  = 1'b0,
    WAIT_SECOND = 1'b1
  } whiten_state_t;

  // A pair is usable only when its two bits differ; the first bit is then the output.
  function automatic logic vn_keep(input logic first_bit, input logic second_bit);
    return first_bit ^ second_bit;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock word FIFO with synchronous active-high reset.
//   i_clk, i_rst     : clock, synchronous reset (empties FIFO, clears storage)
//   i_push, i_data   : write request and word; dropped when full unless a pop happens too
//   i_pop            : read request; ignored while empty
//   o_data           : head entry (registered storage, stable until popped)
//   o_full, o_empty  : status flags
//   o_level          : number of stored words, 0..DEPTH
//   o_push_ok        : the push request this cycle is accepted
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level,
  output logic             o_push_ok
);

  localparam logic [AW:0]   FullLevel = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LevelOne  = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;

  logic pop_eff;
  logic push_eff;

  assign o_full    = (level_q == FullLevel);
  assign o_empty   = (level_q == '0);
  assign o_level   = level_q;
  assign o_data    = mem_q[rd_ptr_q];

  assign pop_eff   = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot the push needs, so full + push + pop succeeds.
  assign push_eff  = i_push & (~o_full | pop_eff);
  assign o_push_ok = push_eff;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_eff) begin
        mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q        <= wr_ptr_q + PtrOne;
      end
      if (pop_eff) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      case ({push_eff, pop_eff})
        2'b10:   level_q <= level_q + LevelOne;
        2'b01:   level_q <= level_q - LevelOne;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/rng_byte_packer.sv
// rng_byte_packer: takes one LFSR bit per enabled cycle, optionally de-biases it with a
// von Neumann corrector, packs accepted bits MSB-first into WORD_BITS-wide words and
// buffers them in a DEPTH-word FIFO behind a valid/ready interface.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_bit, i_bit_valid  : offered random bit (never back-pressured)
//   o_data, o_valid     : FIFO head word / FIFO not empty
//   i_ready             : consumer takes o_data this cycle
//   o_level             : words currently stored, 0..DEPTH
//   o_overflow          : sticky, a completed word was dropped; i_clr_ovf clears it
module rng_byte_packer
  import rng_pkg::*;
#(
  parameter int unsigned WORD_BITS = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WHITEN    = 1,
  localparam int unsigned LW       = $clog2(DEPTH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_bit,
  input  logic                 i_bit_valid,
  output logic [WORD_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [LW-1:0]        o_level,
  output logic                 o_overflow,
  input  logic                 i_clr_ovf
);

  localparam int unsigned CW      = $clog2(WORD_BITS);
  localparam logic [CW-1:0] CntLast = CW'(WORD_BITS - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  whiten_state_t        state_q;
  logic                 pend_q;
  logic [WORD_BITS-1:0] sr_q;
  logic [CW-1:0]        cnt_q;
  logic                 ovf_q;

  logic                 acc_valid;
  logic                 acc_bit;
  logic                 word_done;
  logic [WORD_BITS-1:0] word;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push_ok;
  logic                 drop;

  // Bit acceptance: raw mode passes every offered bit; whitened mode emits the first bit
  // of a differing pair when the second bit arrives.
  always_comb begin
    acc_valid = 1'b0;
    acc_bit   = i_bit;
    if (WHITEN == 0) begin
      acc_valid = i_bit_valid;
    end else if (i_bit_valid && (state_q == WAIT_SECOND) && vn_keep(pend_q, i_bit)) begin
      acc_valid = 1'b1;
      acc_bit   = pend_q;
    end
  end

  assign word      = {sr_q[WORD_BITS-2:0], acc_bit};
  assign word_done = acc_valid && (cnt_q == CntLast);
  assign pop       = o_valid & i_ready;
  assign drop      = word_done & ~push_ok;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= WAIT_FIRST;
      pend_q  <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // Whitening FSM only moves on offered bits; in raw mode it stays in WAIT_FIRST.
      if ((WHITEN != 0) && i_bit_valid) begin
        case (state_q)
          WAIT_FIRST: begin
            pend_q  <= i_bit;
            state_q <= WAIT_SECOND;
          end
          default: begin
            state_q <= WAIT_FIRST;
          end
        endcase
      end

      if (acc_valid) begin
        sr_q  <= word;
        // Counter wraps on completion even if the word is dropped, so the next word
        // always starts on a clean boundary.
        cnt_q <= word_done ? '0 : cnt_q + CntOne;
      end

      // Setting wins over clearing in the same cycle.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (i_clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (word_done),
    .i_data    (word),
    .i_pop     (pop),
    .o_data    (o_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_level   (o_level),
    .o_push_ok (push_ok)
  );

  assign o_valid    = ~fifo_empty;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_rng_byte_packer.sv
// Self-checking bench: a raw (WHITEN=0) and a whitened (WHITEN=1) packer share one input
// stream; a queue-based reference model per instance predicts every output each cycle.
module tb_rng_byte_packer;

  localparam int unsigned WB = 8;
  localparam int unsigned DP = 4;
  localparam int unsigned LW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_in;
  logic          bit_valid;
  logic          ready;
  logic          clr_ovf;

  logic [WB-1:0] r_data, w_data;
  logic          r_valid, w_valid;
  logic [LW-1:0] r_level, w_level;
  logic          r_ovf, w_ovf;

  rng_byte_packer #(
    .WORD_BITS (WB),
    .DEPTH     (DP),
    .WHITEN    (0)
  ) u_raw (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_bit       (bit_in),
    .i_bit_valid (bit_valid),
    .o_data      (r_data),
    .o_valid     (r_valid),
    .i_ready     (ready),
    .o_level     (r_level),
    .o_overflow  (r_ovf),
    .i_clr_ovf   (clr_ovf)
  );

  rng_byte_packer #(
    .WORD_BITS (WB),
    .DEPTH     (DP),
    .WHITEN    (1)
  ) u_wht (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_bit       (bit_in),
    .i_bit_valid (bit_valid),
    .o_data      (w_data),
    .o_valid     (w_valid),
    .i_ready     (ready),
    .o_level     (w_level),
    .o_overflow  (w_ovf),
    .i_clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model, index 0 = raw, 1 = whitened.
  bit            have_p [2];
  bit            pend   [2];
  int unsigned   nacc   [2];
  logic [WB-1:0] wacc   [2];
  logic [WB-1:0] fq     [2][$];
  bit            ovf    [2];

  task automatic model_step(input int m, input logic b, input logic v, input logic rdy,
                            input logic clr, input logic rs);
    bit acc, ab, full, do_pop, dropped;
    if (rs) begin
      have_p[m] = 0; pend[m] = 0; nacc[m] = 0; wacc[m] = '0; ovf[m] = 0;
      fq[m].delete();
      return;
    end
    acc = 0; ab = 0; dropped = 0;
    if (v) begin
      if (m == 0) begin
        acc = 1; ab = b;
      end else if (!have_p[m]) begin
        have_p[m] = 1; pend[m] = b;
      end else begin
        have_p[m] = 0;
        if (b != pend[m]) begin acc = 1; ab = pend[m]; end
      end
    end
    full   = (fq[m].size() == DP);
    do_pop = rdy && (fq[m].size() > 0);
    if (do_pop) void'(fq[m].pop_front());
    if (acc) begin
      wacc[m] = (wacc[m] << 1) | WB'(ab);
      nacc[m]++;
      if (nacc[m] == WB) begin
        if (full && !do_pop) dropped = 1;
        else fq[m].push_back(wacc[m]);
        nacc[m] = 0;
        wacc[m] = '0;
      end
    end
    if (dropped) ovf[m] = 1;
    else if (clr) ovf[m] = 0;
  endtask

  task automatic compare_one(input string tag, input int m, input logic v,
                             input logic [WB-1:0] d, input logic [LW-1:0] l, input logic o);
    check_eq({tag, " valid"}, v, fq[m].size() != 0);
    check_eq({tag, " level"}, l, fq[m].size());
    check_eq({tag, " ovf"}, o, ovf[m]);
    if (fq[m].size() != 0) check_eq({tag, " data"}, d, fq[m][0]);
  endtask

  task automatic cycle(input logic b, input logic v, input logic rdy, input logic clr,
                       input logic rs);
    bit_in = b; bit_valid = v; ready = rdy; clr_ovf = clr; rst = rs;
    model_step(0, b, v, rdy, clr, rs);
    model_step(1, b, v, rdy, clr, rs);
    @(posedge clk);
    #1;
    compare_one("raw", 0, r_valid, r_data, r_level, r_ovf);
    compare_one("wht", 1, w_valid, w_data, w_level, w_ovf);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("rst raw data", r_data, 0);
    check_eq("rst wht data", w_data, 0);
    check_eq("rst raw valid", r_valid, 0);
    check_eq("rst wht ovf", w_ovf, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic feed_bits(input logic [31:0] vec, input int n, input logic rdy);
    for (int i = n - 1; i >= 0; i--) cycle(vec[i], 1'b1, rdy, 1'b0, 1'b0);
  endtask

  task automatic feed_rand(input int n, input logic rdy);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      cycle(b, 1'b1, rdy, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] vec;
    logic        b, v, rdy, clr, rs;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; ready = 1'b0; clr_ovf = 1'b0;

    do_reset();

    // Raw packing of a known byte, MSB first.
    vec = 32'hB2;
    feed_bits(vec, 8, 1'b1);
    check_eq("tp1 valid", r_valid, 1);
    check_eq("tp1 data", r_data, 8'hB2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("tp1 level after pop", r_level, 0);

    // Whitened pairs 01,11,10,00,10,01,01,10,10,10 -> 0x67.
    do_reset();
    vec = 32'h7896A;
    feed_bits(vec, 20, 1'b0);
    check_eq("tp2 valid", w_valid, 1);
    check_eq("tp2 data", w_data, 8'h67);
    check_eq("tp2 level", w_level, 1);

    // Overflow: five words with no consumer.
    do_reset();
    feed_rand(40, 1'b0);
    check_eq("tp3 level", r_level, 4);
    check_eq("tp3 ovf", r_ovf, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("tp3 ovf cleared", r_ovf, 0);
    repeat (6) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("tp3 drained", r_level, 0);

    // Full FIFO, word completes in the same cycle as a pop.
    do_reset();
    feed_rand(39, 1'b0);
    feed_rand(1, 1'b1);
    check_eq("tp4 level", r_level, 4);
    check_eq("tp4 ovf", r_ovf, 0);

    // Reset with full FIFO, overflow set, partial word and a pending whitening bit.
    do_reset();
    feed_rand(45, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("tp5 raw data", r_data, 0);
    check_eq("tp5 raw level", r_level, 0);
    check_eq("tp5 raw ovf", r_ovf, 0);
    check_eq("tp5 wht valid", w_valid, 0);
    feed_rand(16, 1'b0);
    check_eq("tp5 words after reset", r_level, 2);

    // Random traffic with random back-pressure, clears and rare resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      b   = 1'($urandom_range(0, 1));
      v   = ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
      rs  = ($urandom_range(0, 499) == 0);
      cycle(b, v, rdy, clr, rs);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rng_byte_packer.md
# rng_byte_packer

Random-bit packer sitting directly downstream of the Galois LFSR: it takes one LFSR output bit per enabled cycle, optionally removes bias with a von Neumann corrector, packs accepted bits into `WORD_BITS`-wide words and buffers them in a small FIFO behind a valid/ready interface. Consumers include the DAC dither path and the test-mode readout, which drain words at their own pace.

## Interface
Parameters:
- `WORD_BITS`, 8, width of each packed output word (≥ 2).
- `DEPTH`, 4, FIFO depth in words (power of 2, ≥ 2).
- `WHITEN`, 1, 1 = von Neumann corrector enabled, 0 = every offered bit accepted.

Ports (one clock; reset is synchronous and active-high):
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous active-high reset.
- `i_bit` in 1: random bit, LFSR state bit 0.
- `i_bit_valid` in 1: `i_bit` is offered this cycle; never back-pressured.
- `o_data` out `WORD_BITS`: FIFO head word.
- `o_valid` out 1: FIFO not empty.
- `i_ready` in 1: consumer accepts `o_data` this cycle.
- `o_level` out `$clog2(DEPTH)+1`: words currently stored.
- `o_overflow` out 1: sticky; a completed word was dropped.
- `i_clr_ovf` in 1: clears `o_overflow`.

## Operation
- Reset: FIFO empty, `o_valid`=0, `o_level`=0, `o_data`=0, `o_overflow`=0, bit counter 0, shift register 0, whitening FSM in `WAIT_FIRST`.
- Whitening FSM (`WHITEN`=1), advances only on `i_bit_valid`:
  - `WAIT_FIRST`: latch `i_bit` as pending bit, go to `WAIT_SECOND`.
  - `WAIT_SECOND`: if `i_bit` ≠ pending, accept pending bit (01→0, 10→1); if equal, discard both. Always return to `WAIT_FIRST`.
- `WHITEN`=0: each `i_bit_valid` accepts `i_bit` directly; FSM held in `WAIT_FIRST`.
- Packing: accepted bit shifts in at LSB (`sr <= {sr[WORD_BITS-2:0], bit}`), so the first accepted bit ends in the MSB. Counter increments per accepted bit; on the `WORD_BITS`-th bit the completed word (including that bit) is pushed and the counter wraps to 0.
- FIFO: pop when `o_valid & i_ready`; push on word completion. `o_data` is the head entry and holds stable while `o_valid & ~i_ready`.
- Full + push without pop: word dropped, `o_overflow` set, counter still wraps to 0 (the next word starts fresh).
- Full + push + pop in the same cycle: both succeed, no drop, `o_level` unchanged.
- Empty + push + pop: no pop (`o_valid`=0); push lands.
- `i_ready` while empty is ignored.
- `o_overflow`: set has priority over `i_clr_ovf` in the same cycle.
- Reset mid-word discards the partial word and any pending whitening bit; FIFO contents are discarded.
- Width: `o_level` ranges 0..`DEPTH`; write/read pointers are `$clog2(DEPTH)` bits and wrap naturally.

## Timing
- All state is updated on the `i_clk` rising edge; no combinational path from `i_bit`/`i_bit_valid` to any output.
- `i_ready` → pop is combinational into next state only; `o_data`/`o_valid` change on the next edge.
- Latency: a word whose final bit is accepted at edge N has `o_valid`=1 and correct `o_data` from edge N (visible in cycle N+1).
- `WHITEN`=0 throughput: one word per `WORD_BITS` valid cycles. `WHITEN`=1: ≥ 2 valid cycles per accepted bit.

## Structure
- Package `rng_pkg`: enum `whiten_state_t` {`WAIT_FIRST`, `WAIT_SECOND`}.
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`; push/pop/full/empty/level) holds the word buffer; packer and whitening logic live in `rng_byte_packer`.

## Test plan
- `WHITEN`=0, `WORD_BITS`=8: offer bits 1,0,1,1,0,0,1,0 on consecutive cycles with `i_ready`=1 → one cycle after the 8th edge `o_valid`=1, `o_data`=8'hB2, then popped, `o_level` back to 0.
- `WHITEN`=1: pairs 01,11,10,00,10,01,01,10,10,10 → accepted 0,1,1,0,0,1,1,1 → `o_data`=8'h67; pairs 11/00 produce no shift.
- `DEPTH`=4, `i_ready`=0, 5 words pushed → `o_level`=4, fifth word dropped, `o_overflow`=1; `i_clr_ovf` pulse clears it; drained words are the first four in order.
- FIFO full, word completes in the same cycle `i_ready`=1 → no drop, `o_overflow` stays 0, `o_level` stays 4.
- Assert `i_rst` after 5 accepted bits and in `WAIT_SECOND` → after release, next 8 accepted bits form a clean word; all outputs 0 during reset.
- `i_ready` toggled randomly against LFSR bit stream → scoreboard matches reference packing; `o_data` stable while `o_valid & ~i_ready`.
